// File: rtl/instr_decoder.sv
// ID-stage decoder for the MIPS-I/MIPS32 integer subset.
//
// Decodes one 32-bit instruction word per cycle into control flags, a 6-bit
// operation code and HI/LO access info. Every output is registered, so a word
// presented before a rising CLK edge appears on the outputs right after it.
// RESET high at an edge clears every output. Opcodes, functs and REGIMM rt
// values outside the supported subset decode to all-zero outputs.
//
// Ports:
//   CLK           in   rising-edge clock
//   RESET         in   synchronous, active-high reset
//   Instr         in   [31:0] instruction word
//   Instr_PC      in   [31:0] PC of Instr (trace only, no effect on decode)
//   comment1      in   trace enable (trace only, no effect on decode)
//   Link          out  and-link instruction, destination r31
//   RegDest       out  rd is the destination (R-type); rt is a source operand
//   Jump          out  unconditional jump
//   Branch        out  conditional branch
//   MemRead       out  load
//   MemWrite      out  store (including SC)
//   ALUSrc        out  second operand is the immediate
//   RegWrite      out  writes a GPR
//   JumpRegister  out  JR/JALR
//   SignOrZero    out  1 = sign-extend imm16, 0 = zero-extend
//   Syscall       out  pipeline flush request (SYSCALL, LL, SC)
//   ALUControl    out  [5:0] operation code
//   MultRegAccess out  [1:0] 01 = writes HI/LO, 10 = reads HI/LO

module instr_decoder #(
  // Trace prefix only; the synthesized decoder ignores it.
  parameter logic [63:0] TAG = "1"
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr,
  input  logic [31:0] Instr_PC,
  input  logic        comment1,
  output logic        Link,
  output logic        RegDest,
  output logic        Jump,
  output logic        Branch,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        JumpRegister,
  output logic        SignOrZero,
  output logic        Syscall,
  output logic [5:0]  ALUControl,
  output logic [1:0]  MultRegAccess
);

  // Primary opcodes
  localparam logic [5:0] OpSpecial = 6'h00;
  localparam logic [5:0] OpRegimm  = 6'h01;
  localparam logic [5:0] OpJ       = 6'h02;
  localparam logic [5:0] OpJal     = 6'h03;
  localparam logic [5:0] OpBeq     = 6'h04;
  localparam logic [5:0] OpBne     = 6'h05;
  localparam logic [5:0] OpBlez    = 6'h06;
  localparam logic [5:0] OpBgtz    = 6'h07;
  localparam logic [5:0] OpAddi    = 6'h08;
  localparam logic [5:0] OpAddiu   = 6'h09;
  localparam logic [5:0] OpSlti    = 6'h0A;
  localparam logic [5:0] OpSltiu   = 6'h0B;
  localparam logic [5:0] OpAndi    = 6'h0C;
  localparam logic [5:0] OpOri     = 6'h0D;
  localparam logic [5:0] OpXori    = 6'h0E;
  localparam logic [5:0] OpLui     = 6'h0F;
  localparam logic [5:0] OpLb      = 6'h20;
  localparam logic [5:0] OpLh      = 6'h21;
  localparam logic [5:0] OpLw      = 6'h23;
  localparam logic [5:0] OpLbu     = 6'h24;
  localparam logic [5:0] OpLhu     = 6'h25;
  localparam logic [5:0] OpSb      = 6'h28;
  localparam logic [5:0] OpSh      = 6'h29;
  localparam logic [5:0] OpSw      = 6'h2B;
  localparam logic [5:0] OpLl      = 6'h30;
  localparam logic [5:0] OpSc      = 6'h38;

  // SPECIAL functs
  localparam logic [5:0] FnSll     = 6'h00;
  localparam logic [5:0] FnSrl     = 6'h02;
  localparam logic [5:0] FnSra     = 6'h03;
  localparam logic [5:0] FnSllv    = 6'h04;
  localparam logic [5:0] FnSrlv    = 6'h06;
  localparam logic [5:0] FnSrav    = 6'h07;
  localparam logic [5:0] FnJr      = 6'h08;
  localparam logic [5:0] FnJalr    = 6'h09;
  localparam logic [5:0] FnSyscall = 6'h0C;
  localparam logic [5:0] FnMfhi    = 6'h10;
  localparam logic [5:0] FnMthi    = 6'h11;
  localparam logic [5:0] FnMflo    = 6'h12;
  localparam logic [5:0] FnMtlo    = 6'h13;
  localparam logic [5:0] FnMult    = 6'h18;
  localparam logic [5:0] FnMultu   = 6'h19;
  localparam logic [5:0] FnDiv     = 6'h1A;
  localparam logic [5:0] FnDivu    = 6'h1B;
  localparam logic [5:0] FnAdd     = 6'h20;
  localparam logic [5:0] FnAddu    = 6'h21;
  localparam logic [5:0] FnSub     = 6'h22;
  localparam logic [5:0] FnSubu    = 6'h23;
  localparam logic [5:0] FnAnd     = 6'h24;
  localparam logic [5:0] FnOr      = 6'h25;
  localparam logic [5:0] FnXor     = 6'h26;
  localparam logic [5:0] FnNor     = 6'h27;
  localparam logic [5:0] FnSlt     = 6'h2A;
  localparam logic [5:0] FnSltu    = 6'h2B;

  // REGIMM rt selectors
  localparam logic [4:0] RtBltz    = 5'h00;
  localparam logic [4:0] RtBgez    = 5'h01;
  localparam logic [4:0] RtBltzal  = 5'h10;
  localparam logic [4:0] RtBgezal  = 5'h11;

  // HI/LO access encodings
  localparam logic [1:0] HiLoNone  = 2'b00;
  localparam logic [1:0] HiLoWrite = 2'b01;
  localparam logic [1:0] HiLoRead  = 2'b10;

  typedef struct packed {
    logic       link;
    logic       reg_dest;
    logic       jump;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       jump_register;
    logic       sign_or_zero;
    logic       syscall;
    logic [5:0] alu_control;
    logic [1:0] mult_reg_access;
  } ctrl_t;

  logic [5:0] opcode;
  logic [4:0] rt;
  logic [5:0] funct;
  ctrl_t      ctrl_d;
  ctrl_t      ctrl_q;

  assign opcode = Instr[31:26];
  assign rt     = Instr[20:16];
  assign funct  = Instr[5:0];

  // Fields the decoder never looks at, plus trace-only inputs.
  logic unused_inputs;
  assign unused_inputs = ^{TAG, Instr_PC, comment1, Instr[25:21], Instr[15:6]};

  always_comb begin
    ctrl_d = '0;
    case (opcode)
      OpSpecial: begin
        // Common R-type shape; per-funct exceptions patched below.
        ctrl_d.reg_dest    = 1'b1;
        ctrl_d.reg_write   = 1'b1;
        ctrl_d.alu_control = funct;
        case (funct)
          FnSll, FnSrl, FnSra, FnSllv, FnSrlv, FnSrav,
          FnAdd, FnAddu, FnSub, FnSubu, FnAnd, FnOr, FnXor, FnNor,
          FnSlt, FnSltu: begin
          end
          FnJr: begin
            ctrl_d.jump          = 1'b1;
            ctrl_d.jump_register = 1'b1;
            ctrl_d.reg_write     = 1'b0;
          end
          FnJalr: begin
            // Writes rd rather than r31, so no Link.
            ctrl_d.jump          = 1'b1;
            ctrl_d.jump_register = 1'b1;
          end
          FnSyscall: begin
            ctrl_d.syscall   = 1'b1;
            ctrl_d.reg_write = 1'b0;
          end
          FnMfhi, FnMflo: begin
            ctrl_d.mult_reg_access = HiLoRead;
          end
          FnMthi, FnMtlo, FnMult, FnMultu, FnDiv, FnDivu: begin
            ctrl_d.mult_reg_access = HiLoWrite;
            ctrl_d.reg_write       = 1'b0;
          end
          default: ctrl_d = '0;
        endcase
      end

      OpRegimm: begin
        ctrl_d.branch       = 1'b1;
        ctrl_d.sign_or_zero = 1'b1;
        case (rt)
          RtBltz: ctrl_d.alu_control = 6'h15;
          RtBgez: ctrl_d.alu_control = 6'h16;
          RtBltzal: begin
            ctrl_d.alu_control = 6'h35;
            ctrl_d.link        = 1'b1;
            ctrl_d.reg_write   = 1'b1;
          end
          RtBgezal: begin
            ctrl_d.alu_control = 6'h37;
            ctrl_d.link        = 1'b1;
            ctrl_d.reg_write   = 1'b1;
          end
          default: ctrl_d = '0;
        endcase
      end

      OpJ: begin
        ctrl_d.jump        = 1'b1;
        ctrl_d.alu_control = 6'h3B;
      end
      OpJal: begin
        ctrl_d.jump        = 1'b1;
        ctrl_d.link        = 1'b1;
        ctrl_d.reg_write   = 1'b1;
        ctrl_d.alu_control = 6'h3C;
      end

      // BEQ/BNE compare rs with rt, so rt is a source operand.
      OpBeq, OpBne: begin
        ctrl_d.branch       = 1'b1;
        ctrl_d.sign_or_zero = 1'b1;
        ctrl_d.reg_dest     = 1'b1;
        ctrl_d.alu_control  = (opcode == OpBeq) ? 6'h01 : 6'h05;
      end
      OpBlez, OpBgtz: begin
        ctrl_d.branch       = 1'b1;
        ctrl_d.sign_or_zero = 1'b1;
        ctrl_d.alu_control  = (opcode == OpBlez) ? 6'h0E : 6'h0F;
      end

      OpAddi, OpAddiu, OpSlti, OpSltiu: begin
        ctrl_d.alu_src      = 1'b1;
        ctrl_d.reg_write    = 1'b1;
        ctrl_d.sign_or_zero = 1'b1;
        case (opcode)
          OpSlti:  ctrl_d.alu_control = 6'h2A;
          OpSltiu: ctrl_d.alu_control = 6'h2B;
          default: ctrl_d.alu_control = 6'h21;
        endcase
      end
      OpAndi, OpOri, OpXori, OpLui: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        case (opcode)
          OpAndi:  ctrl_d.alu_control = 6'h24;
          OpOri:   ctrl_d.alu_control = 6'h25;
          OpXori:  ctrl_d.alu_control = 6'h26;
          default: ctrl_d.alu_control = 6'h3F;
        endcase
      end

      OpLb, OpLh, OpLw, OpLbu, OpLhu, OpLl: begin
        ctrl_d.mem_read     = 1'b1;
        ctrl_d.reg_write    = 1'b1;
        ctrl_d.alu_src      = 1'b1;
        ctrl_d.sign_or_zero = 1'b1;
        case (opcode)
          OpLb:    ctrl_d.alu_control = 6'h30;
          OpLh:    ctrl_d.alu_control = 6'h31;
          OpLw:    ctrl_d.alu_control = 6'h32;
          OpLbu:   ctrl_d.alu_control = 6'h33;
          OpLhu:   ctrl_d.alu_control = 6'h34;
          default: begin
            // LL opens a link window; ID flushes around it.
            ctrl_d.alu_control = 6'h28;
            ctrl_d.syscall     = 1'b1;
          end
        endcase
      end

      OpSb, OpSh, OpSw: begin
        ctrl_d.mem_write    = 1'b1;
        ctrl_d.alu_src      = 1'b1;
        ctrl_d.sign_or_zero = 1'b1;
        ctrl_d.reg_dest     = 1'b1;
        case (opcode)
          OpSb:    ctrl_d.alu_control = 6'h38;
          OpSh:    ctrl_d.alu_control = 6'h39;
          default: ctrl_d.alu_control = 6'h3A;
        endcase
      end

      // SC stores rt and also writes the success flag back into rt.
      OpSc: begin
        ctrl_d.mem_write    = 1'b1;
        ctrl_d.reg_write    = 1'b1;
        ctrl_d.alu_src      = 1'b1;
        ctrl_d.sign_or_zero = 1'b1;
        ctrl_d.syscall      = 1'b1;
        ctrl_d.alu_control  = 6'h36;
      end

      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign Link          = ctrl_q.link;
  assign RegDest       = ctrl_q.reg_dest;
  assign Jump          = ctrl_q.jump;
  assign Branch        = ctrl_q.branch;
  assign MemRead       = ctrl_q.mem_read;
  assign MemWrite      = ctrl_q.mem_write;
  assign ALUSrc        = ctrl_q.alu_src;
  assign RegWrite      = ctrl_q.reg_write;
  assign JumpRegister  = ctrl_q.jump_register;
  assign SignOrZero    = ctrl_q.sign_or_zero;
  assign Syscall       = ctrl_q.syscall;
  assign ALUControl    = ctrl_q.alu_control;
  assign MultRegAccess = ctrl_q.mult_reg_access;

endmodule

// File: tb/tb_instr_decoder.sv
// Directed bench for instr_decoder: a table of instruction words with
// hand-derived control words applied back to back, plus reset and latency
// sequences.

module tb_instr_decoder;

  logic        CLK;
  logic        RESET;
  logic [31:0] Instr;
  logic [31:0] Instr_PC;
  logic        comment1;
  logic        Link, RegDest, Jump, Branch, MemRead, MemWrite, ALUSrc;
  logic        RegWrite, JumpRegister, SignOrZero, Syscall;
  logic [5:0]  ALUControl;
  logic [1:0]  MultRegAccess;

  instr_decoder #(.TAG("1")) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .Instr        (Instr),
    .Instr_PC     (Instr_PC),
    .comment1     (comment1),
    .Link         (Link),
    .RegDest      (RegDest),
    .Jump         (Jump),
    .Branch       (Branch),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .ALUSrc       (ALUSrc),
    .RegWrite     (RegWrite),
    .JumpRegister (JumpRegister),
    .SignOrZero   (SignOrZero),
    .Syscall      (Syscall),
    .ALUControl   (ALUControl),
    .MultRegAccess(MultRegAccess)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Flag bits, in order Link..Syscall (bit 10..0).
  localparam logic [10:0] FLink = 11'b100_0000_0000;
  localparam logic [10:0] FRd   = 11'b010_0000_0000;
  localparam logic [10:0] FJmp  = 11'b001_0000_0000;
  localparam logic [10:0] FBr   = 11'b000_1000_0000;
  localparam logic [10:0] FMr   = 11'b000_0100_0000;
  localparam logic [10:0] FMw   = 11'b000_0010_0000;
  localparam logic [10:0] FSrc  = 11'b000_0001_0000;
  localparam logic [10:0] FRw   = 11'b000_0000_1000;
  localparam logic [10:0] FJr   = 11'b000_0000_0100;
  localparam logic [10:0] FSx   = 11'b000_0000_0010;
  localparam logic [10:0] FSys  = 11'b000_0000_0001;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [10:0] flags;
    logic [5:0]  alu;
    logic [1:0]  mra;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_bad;

  function automatic vec_t mk(input string name, input logic [31:0] instr,
                              input logic [10:0] flags, input logic [5:0] alu,
                              input logic [1:0] mra);
    vec_t v;
    v.name  = name;
    v.instr = instr;
    v.flags = flags;
    v.alu   = alu;
    v.mra   = mra;
    return v;
  endfunction

  task automatic check(input string name, input logic [10:0] flags,
                       input logic [5:0] alu, input logic [1:0] mra);
    logic [18:0] act;
    logic [18:0] exp;
    act = {Link, RegDest, Jump, Branch, MemRead, MemWrite, ALUSrc, RegWrite,
           JumpRegister, SignOrZero, Syscall, ALUControl, MultRegAccess};
    exp = {flags, alu, mra};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got flags=%b alu=%h mra=%b, want flags=%b alu=%h mra=%b",
               name, act[18:8], act[7:2], act[1:0], exp[18:8], exp[7:2], exp[1:0]);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic rst, input logic [31:0] instr);
    @(negedge CLK);
    RESET    = rst;
    Instr    = instr;
    Instr_PC = Instr_PC + 32'd4;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    RESET    = 1'b1;
    Instr    = 32'h0;
    Instr_PC = 32'h0040_0000;
    comment1 = 1'b0;

    vecs.push_back(mk("add",     32'h012A4020, FRd | FRw,                    6'h20, 2'b00));
    vecs.push_back(mk("ll",      32'hC0880004, FMr | FRw | FSrc | FSx | FSys, 6'h28, 2'b00));
    vecs.push_back(mk("sc",      32'hE0880004, FMw | FRw | FSrc | FSx | FSys, 6'h36, 2'b00));
    vecs.push_back(mk("jal",     32'h0C000010, FJmp | FLink | FRw,           6'h3C, 2'b00));
    vecs.push_back(mk("jr",      32'h03E00008, FJmp | FJr | FRd,             6'h08, 2'b00));
    vecs.push_back(mk("ori",     32'h3508FFFF, FSrc | FRw,                   6'h25, 2'b00));
    vecs.push_back(mk("mult",    32'h00850018, FRd,                          6'h18, 2'b01));
    vecs.push_back(mk("mfhi",    32'h00001010, FRd | FRw,                    6'h10, 2'b10));
    vecs.push_back(mk("bad_op",  32'hFC000000, 11'b0,                        6'h00, 2'b00));
    vecs.push_back(mk("syscall", 32'h0000000C, FRd | FSys,                   6'h0C, 2'b00));
    vecs.push_back(mk("nop",     32'h00000000, FRd | FRw,                    6'h00, 2'b00));
    vecs.push_back(mk("addiu",   32'h24420001, FSrc | FRw | FSx,             6'h21, 2'b00));
    vecs.push_back(mk("lui",     32'h3C011234, FSrc | FRw,                   6'h3F, 2'b00));
    vecs.push_back(mk("lw",      32'h8C820004, FMr | FRw | FSrc | FSx,       6'h32, 2'b00));
    vecs.push_back(mk("sw",      32'hAC820004, FMw | FSrc | FSx | FRd,       6'h3A, 2'b00));
    vecs.push_back(mk("beq",     32'h10820003, FBr | FSx | FRd,              6'h01, 2'b00));
    vecs.push_back(mk("bgtz",    32'h1C800003, FBr | FSx,                    6'h0F, 2'b00));
    vecs.push_back(mk("bgezal",  32'h04910003, FBr | FSx | FLink | FRw,      6'h37, 2'b00));
    vecs.push_back(mk("bltz",    32'h04800003, FBr | FSx,                    6'h15, 2'b00));
    vecs.push_back(mk("bad_rt",  32'h04820003, 11'b0,                        6'h00, 2'b00));
    vecs.push_back(mk("bad_fn",  32'h00000001, 11'b0,                        6'h00, 2'b00));
    vecs.push_back(mk("j",       32'h08000010, FJmp,                         6'h3B, 2'b00));
    vecs.push_back(mk("jalr",    32'h0080F809, FJmp | FJr | FRd | FRw,       6'h09, 2'b00));
    vecs.push_back(mk("mtlo",    32'h00800013, FRd,                          6'h13, 2'b01));
    vecs.push_back(mk("lbu",     32'h90820000, FMr | FRw | FSrc | FSx,       6'h33, 2'b00));
    vecs.push_back(mk("sra",     32'h00021083, FRd | FRw,                    6'h03, 2'b00));
    vecs.push_back(mk("sltiu",   32'h2C820005, FSrc | FRw | FSx,             6'h2B, 2'b00));
    vecs.push_back(mk("xori",    32'h38820005, FSrc | FRw,                   6'h26, 2'b00));

    // Reset, then one ADD so the following reset has something to clear.
    step(1'b1, 32'h0);
    step(1'b1, 32'h0);
    check("reset_idle", 11'b0, 6'h00, 2'b00);
    step(1'b0, 32'h012A4020);
    check("pre_reset_add", FRd | FRw, 6'h20, 2'b00);
    step(1'b1, 32'h0000000C);
    check("reset_overrides", 11'b0, 6'h00, 2'b00);
    step(1'b0, 32'h0000000C);
    check("post_reset_syscall", FRd | FSys, 6'h0C, 2'b00);

    // One-cycle latency: output holds until the edge after Instr changes.
    step(1'b0, 32'hFC000000);
    check("latency_zero", 11'b0, 6'h00, 2'b00);
    @(negedge CLK);
    Instr = 32'h012A4020;
    #1;
    check("latency_hold", 11'b0, 6'h00, 2'b00);
    @(posedge CLK);
    #1;
    check("latency_add", FRd | FRw, 6'h20, 2'b00);

    // Back-to-back table, one instruction per cycle.
    foreach (vecs[i]) begin
      step(1'b0, vecs[i].instr);
      check(vecs[i].name, vecs[i].flags, vecs[i].alu, vecs[i].mra);
    end

    // Mid-stream reset, then decoding resumes on the next edge.
    step(1'b1, 32'h0C000010);
    check("midstream_reset", 11'b0, 6'h00, 2'b00);
    step(1'b0, 32'h0C000010);
    check("resume_jal", FJmp | FLink | FRw, 6'h3C, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_decoder.md
Name: instr_decoder

Overview:
- Registered MIPS-I/MIPS32 integer-subset instruction decoder for the ID stage of the out-of-order core.
- Turns one 32-bit instruction word into control flags, a 6-bit ALU/operation code and HI/LO access info.
- ID uses these outputs for operand selection, rename-queue enqueue and syscall/LL/SC flush sequencing.

Parameters:
TAG, "1", debug string prefixed to trace messages; no functional effect.

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  synchronous, active-high reset
Instr  in  32  instruction word
Instr_PC  in  32  PC of Instr; used for trace output only
comment1  in  1  1 = print one trace line per decode (TAG, PC, instr, ALUControl); no functional effect
Link  out  1  and-link instruction (JAL, BLTZAL, BGEZAL); destination is r31
RegDest  out  1  1 for R-type, BEQ, BNE and stores. For R-type it selects rd as destination; for all four it marks rt as a source operand
Jump  out  1  unconditional jump (J, JAL, JR, JALR)
Branch  out  1  conditional branch
MemRead  out  1  load (LB, LH, LW, LBU, LHU, LL)
MemWrite  out  1  store (SB, SH, SW, SC)
ALUSrc  out  1  second operand is the immediate
RegWrite  out  1  instruction writes a GPR
JumpRegister  out  1  JR/JALR
SignOrZero  out  1  1 = sign-extend imm16, 0 = zero-extend
Syscall  out  1  SYSCALL, LL or SC (pipeline flush request)
ALUControl  out  6  operation code
MultRegAccess  out  2  01 = writes HI/LO (MULT, MULTU, DIV, DIVU, MTHI, MTLO); 10 = reads HI/LO (MFHI, MFLO); else 00

Behaviour:
- All outputs are registered and update on the CLK rising edge from the current Instr; 1-cycle latency. No other state.
- RESET high at a clock edge clears every output to 0, overriding decode. Decoding resumes on the first edge with RESET low.
- R-type (opcode 0), recognised functs only: SLL, SRL, SRA, SLLV, SRLV, SRAV, JR, JALR, SYSCALL, MFHI, MTHI, MFLO, MTLO, MULT, MULTU, DIV, DIVU, ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU.
  - ALUControl = funct.
  - RegDest = 1.
  - RegWrite = 1, except 0 for JR, SYSCALL, MTHI, MTLO, MULT, MULTU, DIV, DIVU.
  - JR, JALR: Jump = 1, JumpRegister = 1; JALR has Link = 0 and writes rd.
  - SYSCALL: Syscall = 1, ALUControl = 0x0C.
  - Instr = 0 (SLL r0) decodes as a normal R-type.
- I-type ALU ops: ALUSrc = 1, RegWrite = 1, RegDest = 0.
  - ADDI/ADDIU -> 0x21, SLTI -> 0x2A, SLTIU -> 0x2B, all with SignOrZero = 1.
  - ANDI -> 0x24, ORI -> 0x25, XORI -> 0x26, LUI -> 0x3F, all with SignOrZero = 0.
- Loads: MemRead = 1, RegWrite = 1, ALUSrc = 1, SignOrZero = 1.
  - Codes: LB 0x30, LH 0x31, LW 0x32, LBU 0x33, LHU 0x34, LL 0x28.
  - LL also sets Syscall = 1.
- Stores: MemWrite = 1, ALUSrc = 1, SignOrZero = 1, RegDest = 1, RegWrite = 0.
  - Codes: SB 0x38, SH 0x39, SW 0x3A.
- SC: MemWrite = 1, RegWrite = 1 (writes rt), RegDest = 0, ALUSrc = 1, SignOrZero = 1, Syscall = 1, ALUControl = 0x36.
- Branches: Branch = 1, SignOrZero = 1.
  - BEQ 0x01 and BNE 0x05 set RegDest = 1.
  - BLEZ 0x0E, BGTZ 0x0F.
  - REGIMM by rt: BLTZ 0x15, BGEZ 0x16, BLTZAL 0x35, BGEZAL 0x37. The AL forms set Link = 1, RegWrite = 1.
- J: Jump = 1, ALUControl = 0x3B. JAL: Jump = 1, Link = 1, RegWrite = 1, ALUControl = 0x3C.
- Any unrecognised opcode, funct or REGIMM rt decodes to all-zero outputs.

Test Plan:
- RESET = 1 while Instr = 0x0000000C -> all outputs 0 after the edge. Release RESET -> next edge gives Syscall = 1, ALUControl = 0x0C, RegWrite = 0.
- Instr = 0x012A4020 (ADD) -> RegDest = 1, RegWrite = 1, ALUSrc = 0, ALUControl = 0x20, exactly 1 cycle later.
- Instr = 0xC0880004 (LL) -> MemRead = 1, RegWrite = 1, Syscall = 1, ALUControl = 0x28. Instr = 0xE0880004 (SC) -> MemWrite = 1, RegWrite = 1, Syscall = 1, ALUControl = 0x36.
- Instr = 0x0C000010 (JAL) -> Jump = 1, Link = 1, RegWrite = 1, RegDest = 0, ALUControl = 0x3C. Instr = 0x03E00008 (JR) -> Jump = 1, JumpRegister = 1, RegWrite = 0.
- Instr = 0x3508FFFF (ORI) -> ALUSrc = 1, SignOrZero = 0, ALUControl = 0x25. Instr = 0x00850018 (MULT) -> MultRegAccess = 01, RegWrite = 0. Instr = 0x00001010 (MFHI) -> MultRegAccess = 10.
- Instr = 0xFC000000 (unused opcode) -> all outputs 0. Back-to-back instructions change outputs every cycle with no bubbles.
